// File: rtl/mult_iterative_pkg.sv
// Shared encodings for the iterative RV32M multiplier: op codes, FSM state
// type and the operand-signedness helpers used at request acceptance.
package mult_iterative_pkg;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic logic a_is_signed(input logic [1:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic b_is_signed(input logic [1:0] op);
        return op == OP_MULH;
    endfunction

endpackage

// File: rtl/mult_digit_step.sv
// One radix-2^DIGIT_W step: adds a * digit, shifted to digit position idx,
// into the double-width accumulator. Purely combinational.
module mult_digit_step #(
    parameter int XLEN    = 32,
    parameter int DIGIT_W = 4,
    parameter int CNT_W   = 3
) (
    input  logic [2*XLEN-1:0]  acc,
    input  logic [XLEN-1:0]    a,
    input  logic [DIGIT_W-1:0] digit,
    input  logic [CNT_W-1:0]   idx,
    output logic [2*XLEN-1:0]  acc_next
);

    logic [XLEN+DIGIT_W-1:0] pp;
    logic [2*XLEN-1:0]       pp_ext;
    logic [2*XLEN-1:0]       pp_shift;

    always_comb begin
        pp       = {{DIGIT_W{1'b0}}, a} * {{XLEN{1'b0}}, digit};
        pp_ext   = {{(XLEN-DIGIT_W){1'b0}}, pp};
        pp_shift = pp_ext << (DIGIT_W * int'(idx));
        acc_next = acc + pp_shift;
    end

endmodule

// File: rtl/mult_iterative.sv
// Iterative RV32M multiplier: sign-magnitude operands, DIGIT_W multiplier bits
// per cycle, final conditional negation, valid/ready result handshake.
module mult_iterative
    import mult_iterative_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DIGIT_W = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] A_i,
    input  logic [XLEN-1:0] B_i,
    input  logic            kill_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output state_t          dbg_state
);

    localparam int N     = XLEN / DIGIT_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]   ONE_X    = XLEN'(1);
    localparam logic [2*XLEN-1:0] ONE_2X   = (2*XLEN)'(1);

    // Handshake: a request transfers on a rising edge with valid_i & ready_o;
    // a result transfers on a rising edge with valid_o & ready_i, and result_o
    // is held stable while valid_o is high and ready_i is low.

    state_t            state;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              sign_q;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;

    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_in_mag;
    logic [XLEN-1:0]   b_in_mag;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] acc_fin;

    // Most-negative operand maps to 2^(XLEN-1), which fits unsigned.
    always_comb begin
        a_neg    = a_is_signed(op_i) & A_i[XLEN-1];
        b_neg    = b_is_signed(op_i) & B_i[XLEN-1];
        a_in_mag = a_neg ? (~A_i + ONE_X) : A_i;
        b_in_mag = b_neg ? (~B_i + ONE_X) : B_i;
    end

    mult_digit_step #(
        .XLEN    (XLEN),
        .DIGIT_W (DIGIT_W),
        .CNT_W   (CNT_W)
    ) u_step (
        .acc      (acc),
        .a        (a_mag),
        .digit    (b_mag[DIGIT_W-1:0]),
        .idx      (cnt),
        .acc_next (acc_step)
    );

    always_comb begin
        acc_fin = acc_step;
        if (sign_q && (acc_step != '0)) begin
            acc_fin = ~acc_step + ONE_2X;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= ST_IDLE;
            op_q   <= OP_MUL;
            a_mag  <= '0;
            b_mag  <= '0;
            sign_q <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (valid_i) begin
                        state  <= ST_CALC;
                        op_q   <= op_i;
                        a_mag  <= a_in_mag;
                        b_mag  <= b_in_mag;
                        sign_q <= a_neg ^ b_neg;
                        cnt    <= '0;
                        acc    <= '0;
                    end
                end
                ST_CALC: begin
                    if (kill_i) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_DONE;
                        acc   <= acc_fin;
                        cnt   <= '0;
                    end else begin
                        acc   <= acc_step;
                        b_mag <= b_mag >> DIGIT_W;
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (kill_i || ready_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o   = (state == ST_IDLE);
        valid_o   = (state == ST_DONE);
        dbg_state = state;
        result_o  = '0;
        if (valid_o) begin
            result_o = (op_q == OP_MUL) ? acc[XLEN-1:0] : acc[2*XLEN-1:XLEN];
        end
    end

endmodule

// File: tb/tb_mult_iterative.sv
// Directed bench for mult_iterative (DIGIT_W = 4) plus a reference-model sweep
// across four instances at DIGIT_W = 1, 2, 4, 8.
module tb_mult_iterative;
    import mult_iterative_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        kill_i = 1'b0;
    logic        ready_i = 1'b1;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] result_o;
    state_t      dbg_state;

    logic        sw_valid = 1'b0;
    logic        sw_ready = 1'b0;
    logic [1:0]  sw_op = 2'b00;
    logic [31:0] sw_a = '0;
    logic [31:0] sw_b = '0;
    logic [3:0]  sw_rdy;
    logic [3:0]  sw_vout;
    logic [31:0] sw_res [4];
    state_t      sw_st [4];

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    mult_iterative #(.XLEN(32), .DIGIT_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .A_i(a_i), .B_i(b_i), .kill_i(kill_i), .valid_o(valid_o),
        .ready_i(ready_i), .result_o(result_o), .dbg_state(dbg_state)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sw
        mult_iterative #(.XLEN(32), .DIGIT_W(1 << g)) u_sw (
            .clk_i(clk), .rst_ni(rst_ni), .valid_i(sw_valid), .ready_o(sw_rdy[g]),
            .op_i(sw_op), .A_i(sw_a), .B_i(sw_b), .kill_i(1'b0), .valid_o(sw_vout[g]),
            .ready_i(sw_ready), .result_o(sw_res[g]), .dbg_state(sw_st[g])
        );
    end

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] sa, sb, p;
        sa = (op == OP_MULH || op == OP_MULHSU) ? {{32{a[31]}}, a} : {32'd0, a};
        sb = (op == OP_MULH) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = sa * sb;
        return (op == OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic kill_at_accept);
        int t;
        t = 0;
        while (!ready_o && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) chk("send_ready_timeout", 32'(t), 32'(0));
        op_i = op; a_i = a; b_i = b; valid_i = 1'b1; kill_i = kill_at_accept;
        tick();
        valid_i = 1'b0; kill_i = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [31:0] exp, input int exp_lat);
        int t;
        t = 0;
        while (!valid_o && t < 40) begin
            tick();
            t++;
        end
        chk({tag, "_lat"}, 32'(t), 32'(exp_lat));
        chk({tag, "_res"}, result_o, exp);
    endtask

    task automatic sweep_one(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e;
        int t;
        e = ref_mul(op, a, b);
        t = 0;
        while (sw_rdy != 4'hF && t < 50) begin
            tick();
            t++;
        end
        sw_op = op; sw_a = a; sw_b = b; sw_valid = 1'b1;
        tick();
        sw_valid = 1'b0;
        t = 0;
        while (sw_vout != 4'hF && t < 40) begin
            tick();
            t++;
        end
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("sweep_dw%0d_op%0d_%h_%h", 1 << g, op, a, b), sw_res[g], e);
        end
        sw_ready = 1'b1;
        tick();
        sw_ready = 1'b0;
    endtask

    initial begin
        // Reset state, observed before any clock edge.
        #1;
        chk("rst_ready", 32'(ready_o), 32'(1));
        chk("rst_valid", 32'(valid_o), 32'(0));
        chk("rst_result", result_o, 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        rst_ni = 1'b1;

        // Basic MUL with latency and return to IDLE.
        send(OP_MUL, 32'd3, 32'd5, 1'b0);
        get_result("mul_3x5", 32'h0000000F, 8);
        tick();
        chk("mul_3x5_ready_after", 32'(ready_o), 32'(1));
        chk("mul_3x5_valid_after", 32'(valid_o), 32'(0));
        chk("mul_3x5_result_after", result_o, 32'h0);

        send(OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        get_result("mulh_m1", 32'h00000000, 8);
        tick();
        send(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        get_result("mulhu_max", 32'hFFFFFFFE, 8);
        tick();
        send(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        get_result("mulhsu_m1", 32'hFFFFFFFF, 8);
        tick();
        send(OP_MULH, 32'h80000000, 32'h80000000, 1'b0);
        get_result("mulh_minneg", 32'h40000000, 8);
        tick();
        send(OP_MUL, 32'h80000000, 32'h80000000, 1'b0);
        get_result("mul_minneg", 32'h00000000, 8);
        tick();

        // Backpressure: result held while ready_i is low.
        ready_i = 1'b0;
        send(OP_MUL, 32'h12345678, 32'h9ABCDEF0, 1'b0);
        get_result("mul_hold", 32'h242D2080, 8);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold_res_%0d", i), result_o, 32'h242D2080);
            chk($sformatf("hold_valid_%0d", i), 32'(valid_o), 32'(1));
            chk($sformatf("hold_ready_%0d", i), 32'(ready_o), 32'(0));
            tick();
        end
        ready_i = 1'b1;
        tick();
        chk("hold_release_ready", 32'(ready_o), 32'(1));

        // Kill in CALC three edges after acceptance.
        send(OP_MULHU, 32'hDEADBEEF, 32'h01234567, 1'b0);
        tick();
        tick();
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        chk("kill_calc_ready", 32'(ready_o), 32'(1));
        chk("kill_calc_state", 32'(dbg_state), 32'(ST_IDLE));
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 10; i++) begin
                if (valid_o) seen++;
                tick();
            end
            chk("kill_calc_no_valid", 32'(seen), 32'(0));
        end
        // kill_i high in IDLE must not block acceptance.
        send(OP_MUL, 32'd7, 32'd6, 1'b1);
        chk("kill_idle_accepted", 32'(dbg_state), 32'(ST_CALC));
        get_result("mul_7x6", 32'h0000002A, 8);
        tick();

        // Kill while holding a result in DONE discards it.
        ready_i = 1'b0;
        send(OP_MUL, 32'd2, 32'd3, 1'b0);
        get_result("mul_2x3", 32'h00000006, 8);
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        ready_i = 1'b1;
        chk("kill_done_valid", 32'(valid_o), 32'(0));
        chk("kill_done_ready", 32'(ready_o), 32'(1));

        // Asynchronous reset mid-CALC.
        send(OP_MUL, 32'hFFFF0000, 32'h0000FFFF, 1'b0);
        tick();
        tick();
        tick();
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", 32'(valid_o), 32'(0));
        chk("arst_result", result_o, 32'h0);
        chk("arst_ready", 32'(ready_o), 32'(1));
        chk("arst_state", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        rst_ni = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                if (valid_o) seen++;
                tick();
            end
            chk("arst_no_valid", 32'(seen), 32'(0));
        end
        // First edge after reset release accepts a request.
        tick();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        send(OP_MULHU, 32'h00010000, 32'h00010000, 1'b0);
        chk("post_rst_accept", 32'(dbg_state), 32'(ST_CALC));
        get_result("post_rst_mulhu", 32'h00000001, 8);
        tick();

        // Sweep every op across all digit widths against the model.
        for (int op = 0; op < 4; op++) begin
            sweep_one(2'(op), 32'h00000000, 32'h00000000);
            sweep_one(2'(op), 32'h80000000, 32'hFFFFFFFF);
            sweep_one(2'(op), 32'h7FFFFFFF, 32'h80000000);
            sweep_one(2'(op), 32'h80000000, 32'h80000000);
            for (int i = 0; i < 5; i++) begin
                sweep_one(2'(op), $urandom(), $urandom());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
